// File: rtl/ic_tester_pkg.sv
// Shared definitions for the logic IC tester: IC codes, expected truth tables, sequencer states.
// Truth-table bit v is the gate output for input {a,b} = v.
package ic_tester_pkg;

    localparam logic [2:0] IC_7400    = 3'd0;
    localparam logic [2:0] IC_7402    = 3'd1;
    localparam logic [2:0] IC_7404    = 3'd2;
    localparam logic [2:0] IC_7408    = 3'd3;
    localparam logic [2:0] IC_7432    = 3'd4;
    localparam logic [2:0] IC_7486    = 3'd5;
    localparam logic [2:0] IC_74266   = 3'd6;
    localparam logic [2:0] IC_INVALID = 3'd7;

    localparam logic [3:0] EXP_NAND = 4'b0111;
    localparam logic [3:0] EXP_NOR  = 4'b0001;
    localparam logic [3:0] EXP_NOT  = 4'b0011;
    localparam logic [3:0] EXP_AND  = 4'b1000;
    localparam logic [3:0] EXP_OR   = 4'b1110;
    localparam logic [3:0] EXP_XOR  = 4'b0110;
    localparam logic [3:0] EXP_XNOR = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_EVAL   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/ic_expected_lut.sv
// Maps an IC code to its expected 4-bit truth table; valid is low for unsupported codes.
module ic_expected_lut
    import ic_tester_pkg::*;
(
    input  logic [2:0] ic_sel,
    output logic [3:0] expected,
    output logic       valid
);

    always_comb begin
        expected = 4'b0000;
        valid    = 1'b1;
        case (ic_sel)
            IC_7400:  expected = EXP_NAND;
            IC_7402:  expected = EXP_NOR;
            IC_7404:  expected = EXP_NOT;
            IC_7408:  expected = EXP_AND;
            IC_7432:  expected = EXP_OR;
            IC_7486:  expected = EXP_XOR;
            IC_74266: expected = EXP_XNOR;
            default:  valid    = 1'b0;
        endcase
    end

endmodule

// File: rtl/ic_test_sequencer.sv
// Applies the four a/b vectors to the IC under test, captures every gate output after a
// settle time, and grades each gate against the expected truth table.
module ic_test_sequencer
    import ic_tester_pkg::*;
#(
    parameter int NUM_GATES     = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [2:0]             ic_sel,
    input  logic [NUM_GATES-1:0]   gate_out,
    output logic                   a,
    output logic                   b,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   fail,
    output logic                   err_ic,
    output logic [NUM_GATES-1:0]   gate_fail,
    output logic [4*NUM_GATES-1:0] obs
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [2:0]         r_sel;
    logic [1:0]         r_vec;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_a;
    logic               r_b;
    logic               r_pass;
    logic               r_fail;
    logic               r_err_ic;

    logic               w_accept;
    logic               w_capture;
    logic [3:0]         w_expected;
    logic               w_valid;
    logic [NUM_GATES-1:0] w_mismatch;

    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_capture = (r_state == ST_SETTLE) && (r_cnt == CNT_LAST);

    ic_expected_lut u_lut (
        .ic_sel   (r_sel),
        .expected (w_expected),
        .valid    (w_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // An invalid code skips the vectors and goes straight to grading, which flags it.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_next = (ic_sel == IC_INVALID) ? ST_EVAL : ST_SETTLE;
            ST_SETTLE: if (w_capture && (r_vec == 2'd3)) w_state_next = ST_EVAL;
            ST_EVAL:   w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel    <= 3'd0;
            r_vec    <= 2'd0;
            r_cnt    <= '0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_pass   <= 1'b0;
            r_fail   <= 1'b0;
            r_err_ic <= 1'b0;
        end else if (w_accept) begin
            r_sel    <= ic_sel;
            r_vec    <= 2'd0;
            r_cnt    <= '0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_pass   <= 1'b0;
            r_fail   <= 1'b0;
            r_err_ic <= 1'b0;
        end else if (r_state == ST_SETTLE) begin
            if (w_capture) begin
                r_cnt <= '0;
                if (r_vec != 2'd3) begin
                    r_vec        <= r_vec + 2'd1;
                    {r_a, r_b}   <= r_vec + 2'd1;
                end else begin
                    {r_a, r_b}   <= 2'b00;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (r_state == ST_EVAL) begin
            r_pass   <= w_valid && (w_mismatch == '0);
            r_fail   <= !(w_valid && (w_mismatch == '0));
            r_err_ic <= !w_valid;
        end
    end

    for (genvar gi = 0; gi < NUM_GATES; gi++) begin : g_gate
        logic [3:0] r_obs_nib;
        logic       r_gate_fail;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_obs_nib   <= 4'b0000;
                r_gate_fail <= 1'b0;
            end else if (w_accept) begin
                r_obs_nib   <= 4'b0000;
                r_gate_fail <= 1'b0;
            end else if (w_capture) begin
                r_obs_nib[r_vec] <= gate_out[gi];
            end else if (r_state == ST_EVAL) begin
                r_gate_fail <= w_valid && w_mismatch[gi];
            end
        end

        assign w_mismatch[gi]     = (r_obs_nib != w_expected);
        assign obs[4*gi +: 4]     = r_obs_nib;
        assign gate_fail[gi]      = r_gate_fail;
    end

    assign a      = r_a;
    assign b      = r_b;
    assign busy   = (r_state == ST_SETTLE) || (r_state == ST_EVAL);
    assign done   = (r_state == ST_DONE);
    assign pass   = r_pass;
    assign fail   = r_fail;
    assign err_ic = r_err_ic;

endmodule
